// File: rtl/uart_hex_rx_to_axi_stream.sv
// UART receiver that parses ASCII hex words into an AXI-stream through a FIFO.
// Define UART_HEX_RX_FRAME_CHECK_EN to drop bytes with a low stop bit and flag frame_err.
module uart_hex_rx_to_axi_stream #(
   parameter int CLK_DIV    = 434,
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_ASIZE = 8
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic                  uart_rx,
   output logic                  tvalid,
   input  logic                  tready,
   output logic [DATA_WIDTH-1:0] tdata,
   output logic                  tlast,
   output logic                  overflow,
   output logic                  frame_err
);

   localparam int CW = $clog2(CLK_DIV + 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);
   localparam logic [CW-1:0] FULL_LAST = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam int DEPTH = 2 ** FIFO_ASIZE;
   localparam logic [FIFO_ASIZE-1:0] PTR_ONE = FIFO_ASIZE'(1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

   // ---------------- line synchroniser ----------------
   logic rx_meta_reg, rx_sync_reg, rx_prev_reg;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         rx_meta_reg <= 1'b1;
         rx_sync_reg <= 1'b1;
         rx_prev_reg <= 1'b1;
      end else begin
         rx_meta_reg <= uart_rx;
         rx_sync_reg <= rx_meta_reg;
         rx_prev_reg <= rx_sync_reg;
      end
   end

   // ---------------- receive FSM ----------------
   rx_state_t       state_reg, state_next;
   logic [CW-1:0]   baud_cnt_reg, baud_cnt_next;
   logic [2:0]      bit_cnt_reg, bit_cnt_next;
   logic [7:0]      shift_reg, shift_next;
   logic [7:0]      rx_byte_reg, rx_byte_next;
   logic            byte_valid_reg, byte_valid_next;
   logic            stop_sample;
   logic            stop_ok;

`ifdef UART_HEX_RX_FRAME_CHECK_EN
   assign stop_ok = rx_sync_reg;
`else
   assign stop_ok = 1'b1;
`endif

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_reg      <= IDLE;
         baud_cnt_reg   <= '0;
         bit_cnt_reg    <= '0;
         shift_reg      <= '0;
         rx_byte_reg    <= '0;
         byte_valid_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         baud_cnt_reg   <= baud_cnt_next;
         bit_cnt_reg    <= bit_cnt_next;
         shift_reg      <= shift_next;
         rx_byte_reg    <= rx_byte_next;
         byte_valid_reg <= byte_valid_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      baud_cnt_next   = baud_cnt_reg;
      bit_cnt_next    = bit_cnt_reg;
      shift_next      = shift_reg;
      rx_byte_next    = rx_byte_reg;
      byte_valid_next = 1'b0;
      stop_sample     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (rx_prev_reg && !rx_sync_reg) begin
               state_next    = START;
               baud_cnt_next = '0;
            end
         end
         START: begin
            if (baud_cnt_reg == HALF_LAST) begin
               baud_cnt_next = '0;
               bit_cnt_next  = '0;
               state_next    = rx_sync_reg ? IDLE : DATA;
            end else begin
               baud_cnt_next = baud_cnt_reg + CNT_ONE;
            end
         end
         DATA: begin
            if (baud_cnt_reg == FULL_LAST) begin
               baud_cnt_next = '0;
               shift_next    = {rx_sync_reg, shift_reg[7:1]};
               bit_cnt_next  = bit_cnt_reg + 3'd1;
               if (bit_cnt_reg == 3'd7)
                  state_next = STOP;
            end else begin
               baud_cnt_next = baud_cnt_reg + CNT_ONE;
            end
         end
         STOP: begin
            if (baud_cnt_reg == FULL_LAST) begin
               // Back to IDLE right at mid stop bit so an early next start edge is caught.
               baud_cnt_next   = '0;
               state_next      = IDLE;
               stop_sample     = 1'b1;
               byte_valid_next = stop_ok;
               rx_byte_next    = shift_reg;
            end else begin
               baud_cnt_next = baud_cnt_reg + CNT_ONE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

`ifdef UART_HEX_RX_FRAME_CHECK_EN
   logic frame_err_reg;
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn)
         frame_err_reg <= 1'b0;
      else if (stop_sample && !rx_sync_reg)
         frame_err_reg <= 1'b1;
   end
   assign frame_err = frame_err_reg;
`else
   assign frame_err = 1'b0;
`endif

   // ---------------- hex parser ----------------
   logic                    is_hex, is_sep, is_nl;
   logic [3:0]              nibble;
   logic [DATA_WIDTH-1:0]   acc_reg;
   logic [DATA_WIDTH+3:0]   acc_shifted;
   logic                    have_digit_reg;
   logic                    push;
   logic [DATA_WIDTH:0]     push_data;

   always_comb begin
      is_hex = 1'b0;
      nibble = '0;
      if (rx_byte_reg >= 8'h30 && rx_byte_reg <= 8'h39) begin
         is_hex = 1'b1;
         nibble = rx_byte_reg[3:0];
      end else if ((rx_byte_reg >= 8'h41 && rx_byte_reg <= 8'h46) ||
                   (rx_byte_reg >= 8'h61 && rx_byte_reg <= 8'h66)) begin
         is_hex = 1'b1;
         nibble = rx_byte_reg[3:0] + 4'd9;
      end
   end

   assign is_nl       = (rx_byte_reg == 8'h0A);
   assign is_sep      = is_nl || (rx_byte_reg == 8'h20);
   assign acc_shifted = {acc_reg, nibble};
   assign push        = byte_valid_reg && is_sep && have_digit_reg;
   assign push_data   = {is_nl, acc_reg};

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         acc_reg        <= '0;
         have_digit_reg <= 1'b0;
      end else if (byte_valid_reg) begin
         if (is_hex) begin
            acc_reg        <= acc_shifted[DATA_WIDTH-1:0];
            have_digit_reg <= 1'b1;
         end else if (is_sep) begin
            acc_reg        <= '0;
            have_digit_reg <= 1'b0;
         end
      end
   end

   // ---------------- output FIFO ----------------
   logic [DATA_WIDTH:0]   mem [DEPTH];
   logic [FIFO_ASIZE-1:0] wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
   logic                  tvalid_reg, tlast_reg, overflow_reg;
   logic [DATA_WIDTH-1:0] tdata_reg;
   logic                  pop, full, wr_en, next_avail;

   assign pop         = tvalid_reg && tready;
   assign full        = (wr_ptr_reg + PTR_ONE) == rd_ptr_reg;
   assign wr_en       = push && (!full || pop);
   assign rd_ptr_next = pop ? rd_ptr_reg + PTR_ONE : rd_ptr_reg;
   // Compare against the current write pointer so the slot being written this cycle is never read.
   assign next_avail  = (wr_ptr_reg != rd_ptr_next);

   always_ff @(posedge aclk) begin
      if (wr_en)
         mem[wr_ptr_reg] <= push_data;
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         overflow_reg <= 1'b0;
         tvalid_reg   <= 1'b0;
         tdata_reg    <= '0;
         tlast_reg    <= 1'b0;
      end else begin
         if (wr_en)
            wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
         if (push && !wr_en)
            overflow_reg <= 1'b1;
         rd_ptr_reg <= rd_ptr_next;
         tvalid_reg <= next_avail;
         if (next_avail)
            {tlast_reg, tdata_reg} <= mem[rd_ptr_next];
      end
   end

   assign tvalid   = tvalid_reg;
   assign tdata    = tdata_reg;
   assign tlast    = tlast_reg;
   assign overflow = overflow_reg;

endmodule
